// File: rtl/fc_layer_engine.sv
`default_nettype none
// ============================================================================
// Module      : fc_layer_engine
// Description : Fully-connected neural-network layer engine. Computes, for
//               each of N_OUT neurons, the dot product of N_IN signed 8-bit
//               activations with N_IN signed 8-bit weights, adds a shifted
//               bias, arithmetically right-shifts, saturates to 8 bits and
//               writes the byte back into activation memory.
//
//               Weight memory layout per neuron j (N_IN+1 bytes each):
//                 W_BASE + j*(N_IN+1) + 0 .. N_IN-1 : weights
//                 W_BASE + j*(N_IN+1) + N_IN        : bias
//               Because the neuron blocks are contiguous, the weight address
//               simply keeps incrementing across the whole layer.
//
// Ports       : clk, reset            - clock, synchronous active-high reset
//               ready / done          - start level / four-phase completion
//               state                 - current FSM state code
//               act_*                 - activation memory (read inputs,
//                                       write results)
//               wgt_*                 - weight/bias memory (read only)
//
// Config      : FC_LAYER_RELU_EN defined   -> result clamped to 0..127
//               FC_LAYER_RELU_EN undefined -> result clamped to -128..127
//
// Revision    : 1.0 - initial release
// ============================================================================
module fc_layer_engine #(
    parameter int ADDR_W     = 16,
    parameter int N_IN       = 784,
    parameter int N_OUT      = 100,
    parameter int IN_BASE    = 0,
    parameter int OUT_BASE   = 1024,
    parameter int W_BASE     = 0,
    parameter int BIAS_SHIFT = 0,
    parameter int OUT_SHIFT  = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ready,
    output logic              done,
    output logic [3:0]        state,
    output logic [ADDR_W-1:0] act_address,
    output logic              act_chipselect,
    output logic              act_clken,
    output logic              act_write,
    output logic [7:0]        act_writedata,
    input  logic [7:0]        act_readdata,
    output logic [ADDR_W-1:0] wgt_address,
    output logic              wgt_chipselect,
    output logic              wgt_clken,
    output logic              wgt_write,
    input  logic [7:0]        wgt_readdata
);

    localparam int CNT_W = 16;

    localparam logic [CNT_W-1:0]  LAST_I    = CNT_W'(N_IN);
    localparam logic [CNT_W-1:0]  LAST_ACT  = CNT_W'(N_IN - 1);
    localparam logic [CNT_W-1:0]  LAST_J    = CNT_W'(N_OUT - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] IN_BASE_A = ADDR_W'(IN_BASE);
    localparam logic [ADDR_W-1:0] OUT_BASE_A = ADDR_W'(OUT_BASE);
    localparam logic [ADDR_W-1:0] W_BASE_A  = ADDR_W'(W_BASE);

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        ISSUE = 4'd1,
        DRAIN = 4'd2,
        WRITE = 4'd3,
        DONE  = 4'd4
    } state_t;

    state_t             st;
    logic [CNT_W-1:0]   in_idx;
    logic [CNT_W-1:0]   out_idx;
    logic [1:0]         drain_cnt;

    // Datapath pipeline: read beat -> captured operands -> product -> acc.
    logic               rd_v, rd_b;
    logic               cap_v, cap_b;
    logic signed [7:0]  cap_a, cap_w;
    logic               prod_v;
    logic signed [31:0] prod;
    logic signed [31:0] acc;

    logic signed [15:0] mult;
    logic signed [31:0] bias_ext;
    logic signed [31:0] acc_next;
    logic signed [31:0] shifted;
    logic [7:0]         sat_byte;

    assign state     = st;
    assign wgt_write = 1'b0;

    always_comb begin
        mult     = cap_a * cap_w;
        bias_ext = {{24{cap_w[7]}}, cap_w} <<< BIAS_SHIFT;
        // acc_next is the value acc takes at the coming edge; the result
        // byte is registered from it so it is ready on entry to WRITE.
        acc_next = prod_v ? (acc + prod) : acc;
        shifted  = acc_next >>> OUT_SHIFT;
`ifdef FC_LAYER_RELU_EN
        if (shifted > 32'sd127)
            sat_byte = 8'h7F;
        else if (shifted < 32'sd0)
            sat_byte = 8'h00;
        else
            sat_byte = shifted[7:0];
`else
        if (shifted > 32'sd127)
            sat_byte = 8'h7F;
        else if (shifted < -32'sd128)
            sat_byte = 8'h80;
        else
            sat_byte = shifted[7:0];
`endif
    end

    // Arithmetic pipeline. The bias beat (last ISSUE cycle) is tagged so its
    // weight byte is sign-extended and shifted instead of multiplied.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_v   <= 1'b0;
            rd_b   <= 1'b0;
            cap_v  <= 1'b0;
            cap_b  <= 1'b0;
            cap_a  <= '0;
            cap_w  <= '0;
            prod_v <= 1'b0;
            prod   <= '0;
            acc    <= '0;
        end else begin
            rd_v   <= (st == ISSUE);
            rd_b   <= (st == ISSUE) && (in_idx == LAST_I);
            cap_v  <= rd_v;
            cap_b  <= rd_b;
            cap_a  <= act_readdata;
            cap_w  <= wgt_readdata;
            prod_v <= cap_v;
            prod   <= cap_b ? bias_ext : {{16{mult[15]}}, mult};
            // Each neuron starts from zero; the pipeline is empty in these states.
            if (st == WRITE || st == IDLE)
                acc <= '0;
            else
                acc <= acc_next;
        end
    end

    // Control FSM with registered memory-interface outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            st             <= IDLE;
            in_idx         <= '0;
            out_idx        <= '0;
            drain_cnt      <= '0;
            done           <= 1'b0;
            act_address    <= '0;
            act_chipselect <= 1'b0;
            act_clken      <= 1'b0;
            act_write      <= 1'b0;
            act_writedata  <= '0;
            wgt_address    <= '0;
            wgt_chipselect <= 1'b0;
            wgt_clken      <= 1'b0;
        end else begin
            act_clken <= 1'b1;
            wgt_clken <= 1'b1;
            case (st)
                IDLE: begin
                    done <= 1'b0;
                    if (ready) begin
                        st             <= ISSUE;
                        in_idx         <= '0;
                        out_idx        <= '0;
                        act_address    <= IN_BASE_A;
                        act_chipselect <= 1'b1;
                        wgt_address    <= W_BASE_A;
                        wgt_chipselect <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (in_idx == LAST_I) begin
                        st             <= DRAIN;
                        drain_cnt      <= '0;
                        act_chipselect <= 1'b0;
                        wgt_chipselect <= 1'b0;
                    end else begin
                        in_idx      <= in_idx + CNT_ONE;
                        wgt_address <= wgt_address + ADDR_ONE;
                        // Next beat is the bias read: activation side goes quiet.
                        if (in_idx == LAST_ACT) begin
                            act_chipselect <= 1'b0;
                            act_address    <= '0;
                        end else begin
                            act_address <= act_address + ADDR_ONE;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == 2'd2) begin
                        st             <= WRITE;
                        act_address    <= OUT_BASE_A + ADDR_W'(out_idx);
                        act_chipselect <= 1'b1;
                        act_write      <= 1'b1;
                        act_writedata  <= sat_byte;
                    end else begin
                        drain_cnt <= drain_cnt + 2'd1;
                    end
                end
                WRITE: begin
                    act_write <= 1'b0;
                    out_idx   <= out_idx + CNT_ONE;
                    if (out_idx == LAST_J) begin
                        st             <= DONE;
                        done           <= 1'b1;
                        act_chipselect <= 1'b0;
                        act_address    <= '0;
                        wgt_address    <= '0;
                    end else begin
                        st             <= ISSUE;
                        in_idx         <= '0;
                        act_address    <= IN_BASE_A;
                        act_chipselect <= 1'b1;
                        // Next neuron's block starts right after this bias.
                        wgt_address    <= wgt_address + ADDR_ONE;
                        wgt_chipselect <= 1'b1;
                    end
                end
                DONE: begin
                    if (!ready) begin
                        st   <= IDLE;
                        done <= 1'b0;
                    end
                end
                default: begin
                    st   <= IDLE;
                    done <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fc_layer_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_fc_layer_engine
// Description : Self-checking bench for fc_layer_engine (N_IN=4, N_OUT=2,
//               OUT_BASE=16, shifts 0). Stimulus pushes expected result
//               writes into a queue; a monitor pops and compares each write.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fc_layer_engine;

    logic        clk;
    logic        reset;
    logic        ready;
    logic        done;
    logic [3:0]  state;
    logic [15:0] act_address;
    logic        act_chipselect, act_clken, act_write;
    logic [7:0]  act_writedata;
    logic [7:0]  act_readdata;
    logic [15:0] wgt_address;
    logic        wgt_chipselect, wgt_clken, wgt_write;
    logic [7:0]  wgt_readdata;

    int compared   = 0;
    int mismatched = 0;

    logic [15:0] exp_q[$];   // {address[7:0], data}
    logic [7:0]  act_mem[256];
    logic [7:0]  wgt_mem[256];

    fc_layer_engine #(
        .ADDR_W(16), .N_IN(4), .N_OUT(2), .IN_BASE(0), .OUT_BASE(16),
        .W_BASE(0), .BIAS_SHIFT(0), .OUT_SHIFT(0)
    ) dut (
        .clk(clk), .reset(reset), .ready(ready), .done(done), .state(state),
        .act_address(act_address), .act_chipselect(act_chipselect),
        .act_clken(act_clken), .act_write(act_write),
        .act_writedata(act_writedata), .act_readdata(act_readdata),
        .wgt_address(wgt_address), .wgt_chipselect(wgt_chipselect),
        .wgt_clken(wgt_clken), .wgt_write(wgt_write),
        .wgt_readdata(wgt_readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memories: data valid the cycle after a read select.
    always @(posedge clk) begin
        if (act_chipselect && !act_write)
            act_readdata <= act_mem[act_address[7:0]];
        if (wgt_chipselect && !wgt_write)
            wgt_readdata <= wgt_mem[wgt_address[7:0]];
    end

    // Monitor: every result write must match the head of the queue.
    always @(negedge clk) begin
        if (act_chipselect && act_write) begin
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL write_unexpected: got addr=%0d data=%02h, required no write",
                         act_address, act_writedata);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (act_address != {8'h00, e[15:8]} || act_writedata != e[7:0]) begin
                    mismatched++;
                    $display("FAIL write: got addr=%0d data=%02h, required addr=%0d data=%02h",
                             act_address, act_writedata, e[15:8], e[7:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("FAIL %s: got %0d, required %0d", name, actual, expected);
        end
    endtask

    task automatic load_mem(input logic [7:0] a, input logic [7:0] w, input logic [7:0] b);
        for (int k = 0; k < 4; k++) act_mem[k] = a;
        for (int j = 0; j < 2; j++) begin
            for (int k = 0; k < 4; k++) wgt_mem[j*5 + k] = w;
            wgt_mem[j*5 + 4] = b;
        end
    endtask

    task automatic push_results(input logic [7:0] v);
        exp_q.push_back({8'd16, v});
        exp_q.push_back({8'd17, v});
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_state"}, int'(state), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_ctrl"}, int'({act_chipselect, act_write, wgt_chipselect, wgt_write}), 0);
        chk({tag, "_addr"}, int'(act_address) + int'(wgt_address), 0);
        chk({tag, "_wdata"}, int'(act_writedata), 0);
    endtask

    // Called #1 after an edge with the engine idle. ready is high in cycle 0.
    // hold: keep ready high until done; pulse5: extra one-cycle pulse at cycle 5.
    task automatic run_layer(input string tag, input bit hold, input bit pulse5);
        int n;
        int got;
        n   = 0;
        got = -1;
        ready = 1'b1;
        while (n < 60 && got < 0) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) chk({tag, "_issue_state"}, int'(state), 1);
            if (!hold && n == 1) ready = 1'b0;
            if (pulse5 && n == 5) ready = 1'b1;
            if (pulse5 && n == 6) ready = 1'b0;
            if (done) got = n;
        end
        chk({tag, "_done_cycle"}, got, 19);
        if (hold) begin
            repeat (3) begin @(posedge clk); #1; end
            chk({tag, "_done_held"}, int'(done), 1);
            ready = 1'b0;
        end
        @(posedge clk); #1;
        chk({tag, "_after_done"}, int'({done, state}), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 256; k++) begin
            act_mem[k] = 8'h00;
            wgt_mem[k] = 8'h00;
        end
        reset = 1'b1;
        ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        reset = 1'b0;
        @(posedge clk); #1;
        chk("clken", int'({act_clken, wgt_clken}), 3);

        // 4*(1*2)+3 = 11
        load_mem(8'd1, 8'd2, 8'd3);
        push_results(8'h0B);
        run_layer("basic", 1'b1, 1'b0);

        // 4*127*127+127 saturates high
        load_mem(8'd127, 8'd127, 8'd127);
        push_results(8'h7F);
        run_layer("sat_hi", 1'b1, 1'b0);

        // 4*127*(-128) = -65024
        load_mem(8'd127, 8'h80, 8'h00);
`ifdef FC_LAYER_RELU_EN
        push_results(8'h00);
`else
        push_results(8'h80);
`endif
        run_layer("sat_lo", 1'b1, 1'b0);

        // Single-pulse start with a second pulse ignored mid-run
        load_mem(8'd1, 8'd2, 8'd3);
        push_results(8'h0B);
        run_layer("pulse", 1'b0, 1'b1);
        repeat (25) begin @(posedge clk); #1; end
        chk("pulse_no_restart", int'(state), 0);

        // Reset asserted in cycle 7 of a run, then a clean rerun
        ready = 1'b1;
        for (int n = 1; n <= 7; n++) begin @(posedge clk); #1; end
        reset = 1'b1;
        ready = 1'b0;
        @(posedge clk); #1;
        check_idle_outputs("midreset");
        reset = 1'b0;
        repeat (20) begin @(posedge clk); #1; end
        chk("midreset_idle", int'(state), 0);
        push_results(8'h0B);
        run_layer("rerun", 1'b1, 1'b0);

        repeat (5) @(posedge clk);
        #1;
        chk("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fc_layer_engine.md
FC_LAYER_ENGINE -- requirements
Module: fc_layer_engine

Interface
REQ-001 Parameters (name, default, meaning): ADDR_W, 16, memory address width; N_IN, 784, inputs per neuron (1..65535); N_OUT, 100, neurons per layer (1..65535); IN_BASE, 0, first input activation address; OUT_BASE, 1024, first result address; W_BASE, 0, first weight address; BIAS_SHIFT, 0, left shift applied to bias; OUT_SHIFT, 7, arithmetic right shift applied to accumulator.
REQ-002 Ports (name, direction, width, meaning):
- clk  in  1  single clock, all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- ready  in  1  start request from layer control, level.
- done  out  1  layer complete, four-phase handshake.
- state  out  4  FSM state code.
- act_address  out  ADDR_W  activation memory address.
- act_chipselect / act_clken / act_write  out  1 each  activation memory controls.
- act_writedata  out  8  result byte.
- act_readdata  in  8  activation byte, signed.
- wgt_address  out  ADDR_W  weight memory address.
- wgt_chipselect / wgt_clken / wgt_write  out  1 each  weight memory controls; wgt_write constant 0.
- wgt_readdata  in  8  weight/bias byte, signed.
REQ-003 Both memories SHALL be treated as synchronous: readdata valid exactly one cycle after chipselect=1, write=0; act_clken and wgt_clken SHALL be held 1 outside reset.

Function
REQ-004 States (code): IDLE=0, ISSUE=1, DRAIN=2, WRITE=3, DONE=4; state output SHALL equal the current code.
REQ-005 IDLE->ISSUE when ready=1 in IDLE; neuron index j and input index i cleared, accumulator cleared.
REQ-006 ISSUE lasts N_IN+1 cycles: for i<N_IN drive act_address=IN_BASE+i, wgt_address=W_BASE+j*(N_IN+1)+i, both chipselects 1; at i=N_IN drive wgt_address for bias only, act_chipselect=0.
REQ-007 Pipeline: readdata captured cycle t+1, signed 8x8 product registered t+2, added to 32-bit signed accumulator t+3; bias added as sign-extended bias<<BIAS_SHIFT.
REQ-008 DRAIN lasts exactly 3 cycles, both chipselects 0; then WRITE.
REQ-009 WRITE (1 cycle): act_address=OUT_BASE+j, act_chipselect=1, act_write=1, act_writedata=sat(acc>>>OUT_SHIFT); then j increments; next ISSUE if j<N_OUT-1 else DONE.
REQ-010 Saturation: result clamped to signed 8-bit range per REQ-018.
REQ-011 Each neuron occupies N_IN+5 cycles; with ready sampled high at cycle 0, done SHALL first be 1 at cycle 1+N_OUT*(N_IN+5).
REQ-012 DONE: done=1; remain while ready=1; ready=0 -> IDLE next cycle, done=0; if ready already 0 on entry, done high exactly one cycle.
REQ-013 ready changes outside IDLE/DONE SHALL be ignored; a run always completes.
REQ-014 act_write=1 only in WRITE; no memory access in IDLE or DONE.
REQ-015 Overlap of OUT_BASE region with IN_BASE region is a usage error; behaviour undefined, not checked.

Reset
REQ-016 reset=1 at any clock edge, including mid-run: next cycle state=IDLE, done=0, all chipselects/writes 0, addresses 0, act_writedata 0, accumulator and indices 0; no write issued in that cycle.
REQ-017 First ready=1 after reset release starts a clean run with no residue from the aborted run.

Configuration
REQ-018 Macro FC_LAYER_RELU_EN: defined -> result clamped to 0..127 (ReLU + saturate); undefined -> clamped to -128..127 (signed saturate, no ReLU).

Verification (N_IN=4, N_OUT=2, W_BASE=0, IN_BASE=0, OUT_BASE=16, BIAS_SHIFT=0, OUT_SHIFT=0)
REQ-019 acts all 1, weights 2, biases 3, ready held high -> 0x0B written at 16 and 17; done first 1 at cycle 19; stays 1 until ready drops, then IDLE.
REQ-020 acts 127, weights 127 -> 0x7F written both addresses (saturated, either config).
REQ-021 acts 127, weights -128, bias 0 -> 0x00 with FC_LAYER_RELU_EN, 0x80 without.
REQ-022 one-cycle ready pulse; second pulse at cycle 5 -> single run, done high exactly one cycle at 19, no restart.
REQ-023 reset at cycle 7 -> cycle 8 state=0, all outputs 0, no write to 16; new ready -> REQ-019 results repeated exactly.
